// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants for the raster timing generator.
//
// Holds the default 640x480@60 timing (25.175 MHz pixel rate), the sync
// polarity encodings and the bundle type carried through the output delay line.
package vga_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    localparam logic DEF_H_POL = POL_ACTIVE_LOW;
    localparam logic DEF_V_POL = POL_ACTIVE_LOW;

    localparam int DEF_PIPE_DLY = 2;
    localparam int DEF_SCALE_SH = 1;

    // Sync/bright bundle as it travels through the delay line. hs/vs are
    // already at their output polarity.
    typedef struct packed {
        logic hs;
        logic vs;
        logic br;
    } sync_bits_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line -- enable-gated shift register of parametrised depth.
//
// Parameters:
//   WIDTH    bits per stage
//   DEPTH    number of stages (>= 1); dout lags din by DEPTH enabled clocks
//   RST_VAL  value loaded into every stage on reset
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   shift enable
//   din    in   WIDTH  stage-1 input
//   dout   out  WIDTH  last stage
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- programmable raster timing generator.
//
// Counts pixels/lines on each pixel tick (pix_en), decodes sync and visible
// region, and delays those by PIPE_DLY ticks to line up with the downstream
// pixel pipeline. Also produces single-clock line/frame/vblank pulses for the
// PPU.
//
// Optional feature: define VGA_PIXEL_SCALE_EN to add the nes_x/nes_y ports
// (hCount/vCount shifted right by SCALE_SH).
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   pix_en        in   pixel tick; all state advances only when high
//   hCount        out  current pixel column (undelayed)
//   vCount        out  current line (undelayed)
//   hSync         out  horizontal sync, active level H_POL, PIPE_DLY ticks late
//   vSync         out  vertical sync, active level V_POL, PIPE_DLY ticks late
//   bright        out  visible region, PIPE_DLY ticks late
//   line_start    out  one-clk pulse when hCount has just become 0
//   frame_start   out  one-clk pulse when hCount and vCount have just become 0
//   vblank_start  out  one-clk pulse when vCount has just become V_DISPLAY
//   nes_x, nes_y  out  scaled counters (VGA_PIXEL_SCALE_EN only)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_BOTTOM  = DEF_V_BOTTOM,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_TOP     = DEF_V_TOP,
    parameter logic H_POL     = DEF_H_POL,
    parameter logic V_POL     = DEF_V_POL,
    parameter int   PIPE_DLY  = DEF_PIPE_DLY,
    parameter int   SCALE_SH  = DEF_SCALE_SH
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    output logic [$clog2(H_DISPLAY+H_FRONT+H_SYNC+H_BACK)-1:0] hCount,
    output logic [$clog2(V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP)-1:0] vCount,
    output logic hSync,
    output logic vSync,
    output logic bright,
    output logic line_start,
    output logic frame_start,
`ifdef VGA_PIXEL_SCALE_EN
    output logic [$clog2(H_DISPLAY+H_FRONT+H_SYNC+H_BACK)-SCALE_SH-1:0] nes_x,
    output logic [$clog2(V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP)-SCALE_SH-1:0] nes_y,
`endif
    output logic vblank_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DISP   = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DISP   = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_PRE_VB = VW'(V_DISPLAY - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_BOTTOM);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    // Idle value of every delay stage: both syncs inactive, not visible.
    localparam sync_bits_t IDLE_BITS = '{hs: ~H_POL, vs: ~V_POL, br: 1'b0};

    logic       hs_raw;
    logic       vs_raw;
    logic       br_raw;
    sync_bits_t raw_bits;
    sync_bits_t dly_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCount       <= '0;
            vCount       <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_en) begin
                if (hCount == H_MAX) begin
                    hCount       <= '0;
                    vCount       <= (vCount == V_MAX) ? '0 : vCount + 1'b1;
                    // Pulses land in the same clock the wrapped counters appear.
                    line_start   <= 1'b1;
                    frame_start  <= (vCount == V_MAX);
                    vblank_start <= (vCount == V_PRE_VB);
                end else begin
                    hCount <= hCount + 1'b1;
                end
            end
        end
    end

    assign hs_raw = (hCount >= HS_FIRST) && (hCount <= HS_LAST);
    assign vs_raw = (vCount >= VS_FIRST) && (vCount <= VS_LAST);
    assign br_raw = (hCount < H_DISP) && (vCount < V_DISP);

    // Polarity is applied before the delay line so the stages reset to the
    // true idle levels and the outputs need no further logic.
    assign raw_bits.hs = hs_raw ^ ~H_POL;
    assign raw_bits.vs = vs_raw ^ ~V_POL;
    assign raw_bits.br = br_raw;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (IDLE_BITS)
    ) u_delay (
        .clk   (clk),
        .rst_n (reset),
        .en    (pix_en),
        .din   (raw_bits),
        .dout  (dly_bits)
    );

    assign hSync  = dly_bits.hs;
    assign vSync  = dly_bits.vs;
    assign bright = dly_bits.br;

`ifdef VGA_PIXEL_SCALE_EN
    assign nes_x = hCount[HW-1:SCALE_SH];
    assign nes_y = vCount[VW-1:SCALE_SH];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32x17 ticks per frame) so
// several whole frames fit in a short run. The reference model derives every
// output from the number of pixel ticks since reset.
module tb_vga_timing_gen;

    localparam int   HD = 16, HF = 4, HS = 6, HB = 6;
    localparam int   VD = 10, VB = 2, VS = 2, VT = 3;
    localparam int   HT = HD + HF + HS + HB;   // 32
    localparam int   VTOT = VD + VB + VS + VT; // 17
    localparam int   DLY = 3;
    localparam logic HP = 1'b1;
    localparam logic VP = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [4:0] hCount;
    logic [4:0] vCount;
    logic       hSync, vSync, bright;
    logic       line_start, frame_start, vblank_start;
`ifdef VGA_PIXEL_SCALE_EN
    logic [3:0] nes_x;
    logic [3:0] nes_y;
`endif

    vga_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_BOTTOM (VB), .V_SYNC (VS), .V_TOP (VT),
        .H_POL (HP), .V_POL (VP), .PIPE_DLY (DLY), .SCALE_SH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_en       (pix_en),
        .hCount       (hCount),
        .vCount       (vCount),
        .hSync        (hSync),
        .vSync        (vSync),
        .bright       (bright),
        .line_start   (line_start),
        .frame_start  (frame_start),
`ifdef VGA_PIXEL_SCALE_EN
        .nes_x        (nes_x),
        .nes_y        (nes_y),
`endif
        .vblank_start (vblank_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit br;
        bit ls;
        bit fs;
        bit vbs;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   t = 0;      // pixel ticks since the last reset
    int   n_frames = 0;
    int   n_vblank = 0;

    // Expected outputs after 'tick' pixel ticks; 'jt' says the clock just
    // taken was a pixel tick (pulses can only appear then).
    function automatic exp_t model(input int tick, input bit jt);
        exp_t e;
        int   d, h, v;
        e.h = tick % HT;
        e.v = (tick / HT) % VTOT;
        if (tick >= DLY) begin
            d    = tick - DLY;
            h    = d % HT;
            v    = (d / HT) % VTOT;
            e.hs = (h >= HD + HF && h < HD + HF + HS) ? HP : !HP;
            e.vs = (v >= VD + VB && v < VD + VB + VS) ? VP : !VP;
            e.br = (h < HD) && (v < VD);
        end else begin
            e.hs = !HP;
            e.vs = !VP;
            e.br = 1'b0;
        end
        e.ls  = jt && (e.h == 0);
        e.fs  = e.ls && (e.v == 0);
        e.vbs = e.ls && (e.v == VD);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a new output set every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hCount", int'(hCount), e.h);
                check("vCount", int'(vCount), e.v);
                check("hSync", int'(hSync), int'(e.hs));
                check("vSync", int'(vSync), int'(e.vs));
                check("bright", int'(bright), int'(e.br));
                check("line_start", int'(line_start), int'(e.ls));
                check("frame_start", int'(frame_start), int'(e.fs));
                check("vblank_start", int'(vblank_start), int'(e.vbs));
`ifdef VGA_PIXEL_SCALE_EN
                check("nes_x", int'(nes_x), e.h >> 1);
                check("nes_y", int'(nes_y), e.v >> 1);
`endif
                if (e.fs) n_frames++;
                if (e.vbs) n_vblank++;
            end
        end
    end

    task automatic cycle(input bit en);
        @(negedge clk);
        pix_en = en;
        if (en) t++;
        q.push_back(model(t, en));
    endtask

    // Assert reset mid-run; counters and syncs must drop without a clock edge.
    task automatic do_reset(input int hold);
        @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'($urandom_range(0, 1));
        t      = 0;
        #1;
        check("async_rst_hCount", int'(hCount), 0);
        check("async_rst_vCount", int'(vCount), 0);
        check("async_rst_hSync", int'(hSync), int'(!HP));
        check("async_rst_vSync", int'(vSync), int'(!VP));
        check("async_rst_bright", int'(bright), 0);
        q.push_back(model(0, 1'b0));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            q.push_back(model(0, 1'b0));
        end
        @(negedge clk);
        reset  = 1'b1;
        pix_en = 1'b1;
        t      = 1;
        q.push_back(model(t, 1'b1));
    endtask

    initial begin
        reset  = 1'b0;
        pix_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            q.push_back(model(0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        q.push_back(model(0, 1'b0));

        // Continuous ticks: two full frames plus a little.
        repeat (2 * HT * VTOT + 10) cycle(1'b1);

        // Alternating ticks: a frame takes twice as many clocks.
        for (int i = 0; i < 2 * HT * VTOT; i++) cycle(i % 2 == 0);

        // Reset inside the horizontal sync window.
        while ((t % HT) != HD + HF + 2) cycle(1'b1);
        do_reset(2);

        // Random ticks with the occasional reset.
        repeat (3000) begin
            cycle($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 799) == 0) do_reset($urandom_range(1, 3));
        end

        @(negedge clk);
        pix_en = 1'b0;
        q.push_back(model(t, 1'b0));
        repeat (3) @(negedge clk);

        check("queue_drained", q.size(), 0);
        checks++;
        if (n_frames < 3 || n_vblank < 3) begin
            errors++;
            $display("FAIL pulse_count: frames %0d vblanks %0d required at least 3 each", n_frames, n_vblank);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
